// File: rtl/rr_requester.sv
// rr_requester: four independent command channels feeding a round-robin arbiter.
// A command is offered on one shared port and goes to a channel named by cmd_ch.
// That channel then raises its Req bit and counts one data beat on each cycle the
// arbiter grants it. It pulses done once after the last beat. If it waits TIMEOUT
// consecutive cycles without a grant, it aborts to a sticky error state.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   cmd_valid  command offered this cycle
//   cmd_ch     target channel of the offered command
//   cmd_len    beats minus one
//   cmd_ready  target channel is idle (combinational)
//   Req        registered per-channel request to the arbiter
//   Grant      grant from the arbiter (expected one-hot or zero)
//   beat       Req & Grant, a data beat moves on channel i when set
//   done       registered one-cycle completion pulse per channel
//   err        sticky per-channel timeout flag
//   err_clr    per-channel error clear, only honoured in the error state
//   grant_err  sticky protocol violation flag (stray or multiple grants)
module rr_requester #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_ch,
  input  logic [3:0] cmd_len,
  output logic       cmd_ready,
  output logic [3:0] Req,
  input  logic [3:0] Grant,
  output logic [3:0] beat,
  output logic [3:0] done,
  output logic [3:0] err,
  input  logic [3:0] err_clr,
  output logic       grant_err
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e     state_q [4];
  logic [3:0] rem_q   [4];
  logic [7:0] wait_q  [4];

  assign cmd_ready = (state_q[cmd_ch] == StIdle);
  assign beat      = Req & Grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StIdle;
        rem_q[i]   <= 4'd0;
        wait_q[i]  <= 8'd0;
      end
      Req       <= 4'b0;
      done      <= 4'b0;
      err       <= 4'b0;
      grant_err <= 1'b0;
    end else begin
      // Stray grant (channel not requesting) or more than one grant bit set.
      if ((|(Grant & ~Req)) || ((Grant & (Grant - 4'd1)) != 4'd0)) begin
        grant_err <= 1'b1;
      end

      for (int i = 0; i < 4; i++) begin
        automatic state_e nxt = state_q[i];
        unique case (state_q[i])
          StIdle: begin
            if (cmd_valid && (cmd_ch == 2'(i))) begin
              nxt        = StReq;
              rem_q[i]  <= cmd_len;
              wait_q[i] <= 8'd0;
            end
          end
          StReq: begin
            // A granted cycle never times out, so a final beat always wins.
            if (Grant[i]) begin
              wait_q[i] <= 8'd0;
              if (rem_q[i] == 4'd0) begin
                nxt = StDone;
              end else begin
                rem_q[i] <= rem_q[i] - 4'd1;
              end
            end else if (wait_q[i] + 8'd1 == TimeoutCnt) begin
              nxt        = StErr;
              wait_q[i] <= wait_q[i] + 8'd1;
            end else begin
              wait_q[i] <= wait_q[i] + 8'd1;
            end
          end
          StDone: nxt = StIdle;
          StErr: begin
            if (err_clr[i]) begin
              nxt = StIdle;
            end
          end
          default: nxt = StIdle;
        endcase
        state_q[i] <= nxt;
        Req[i]     <= (nxt == StReq);
        done[i]    <= (nxt == StDone);
        err[i]     <= (nxt == StErr);
      end
    end
  end

endmodule

// File: tb/tb_rr_requester.sv
module tb_rr_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_ch;
  logic [3:0] cmd_len;
  logic       cmd_ready;
  logic [3:0] Req;
  logic [3:0] Grant;
  logic [3:0] beat;
  logic [3:0] done;
  logic [3:0] err;
  logic [3:0] err_clr;
  logic       grant_err;

  int errors = 0;
  int checks = 0;

  rr_requester #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ch    (cmd_ch),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .Req       (Req),
    .Grant     (Grant),
    .beat      (beat),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr),
    .grant_err (grant_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge, settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] ch, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_ch = 2'd0; cmd_len = 4'd0;
    Grant = 4'b0; err_clr = 4'b0;
    #12;
    chk("rst_req", 8'(Req), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_err", 8'(err), 8'h0);
    chk("rst_gerr", 8'(grant_err), 8'h0);
    chk("rst_ready", 8'(cmd_ready), 8'h1);
    rst = 1'b1;

    // Single transfer, 3 beats on ch0
    send(2'd0, 4'd2);
    chk("s_req", 8'(Req), 8'h1);
    Grant = 4'b0001;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk($sformatf("s_beat%0d", b), 8'(beat), 8'h1);
      tick();
    end
    Grant = 4'b0000;
    #1;
    chk("s_done", 8'(done), 8'h1);
    chk("s_req_off", 8'(Req), 8'h0);
    tick();
    chk("s_done_pulse", 8'(done), 8'h0);
    chk("s_ready", 8'(cmd_ready), 8'h1);
    chk("s_gerr", 8'(grant_err), 8'h0);

    // Interleaved grants, ch1 and ch2 two beats each
    send(2'd1, 4'd1);
    send(2'd2, 4'd1);
    chk("i_req", 8'(Req), 8'h6);
    Grant = 4'b0010; #1; chk("i_b1a", 8'(beat), 8'h2); tick();
    Grant = 4'b0100; #1; chk("i_b2a", 8'(beat), 8'h4); tick();
    Grant = 4'b0010; #1; chk("i_b1b", 8'(beat), 8'h2); tick();
    Grant = 4'b0100;
    #1;
    chk("i_done1", 8'(done), 8'h2);
    chk("i_req2", 8'(Req), 8'h4);
    tick();
    Grant = 4'b0000;
    #1;
    chk("i_done2", 8'(done), 8'h4);
    chk("i_req_off", 8'(Req), 8'h0);
    tick();
    chk("i_quiet", 8'(done), 8'h0);
    chk("i_gerr", 8'(grant_err), 8'h0);

    // Busy channel: second command must be held and ignored
    send(2'd0, 4'd1);
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_len = 4'd5;
    Grant = 4'b0001;
    #1;
    chk("b_ready", 8'(cmd_ready), 8'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    Grant = 4'b0000;
    #1;
    chk("b_done", 8'(done), 8'h1);
    chk("b_req_off", 8'(Req), 8'h0);
    tick();

    // Timeout on ch3
    send(2'd3, 4'd0);
    n = 0;
    while (Req[3] && n < 40) begin
      n++;
      tick();
    end
    chk("t_cycles", 8'(n), 8'd15);
    chk("t_err", 8'(err), 8'h8);
    chk("t_req", 8'(Req), 8'h0);
    chk("t_nodone", 8'(done), 8'h0);
    cmd_ch = 2'd3;
    #1;
    chk("t_ready_busy", 8'(cmd_ready), 8'h0);
    err_clr = 4'b1000;
    tick();
    err_clr = 4'b0000;
    #1;
    chk("t_err_clr", 8'(err), 8'h0);
    chk("t_ready", 8'(cmd_ready), 8'h1);

    // Stray grant
    Grant = 4'b0001;
    tick();
    Grant = 4'b0000;
    #1;
    chk("p_gerr", 8'(grant_err), 8'h1);
    chk("p_req", 8'(Req), 8'h0);
    chk("p_done", 8'(done), 8'h0);
    tick();
    cmd_ch = 2'd0;
    #1;
    chk("p_gerr_sticky", 8'(grant_err), 8'h1);
    chk("p_ready", 8'(cmd_ready), 8'h1);

    // Reset during beat 2 of 4
    send(2'd0, 4'd3);
    Grant = 4'b0001;
    tick();
    #1;
    rst = 1'b0;
    #1;
    chk("r_req", 8'(Req), 8'h0);
    chk("r_gerr", 8'(grant_err), 8'h0);
    chk("r_beat", 8'(beat), 8'h0);
    Grant = 4'b0000;
    tick();
    chk("r_nodone", 8'(done), 8'h0);
    @(negedge clk);
    rst = 1'b1;
    send(2'd0, 4'd0);
    chk("r_req_new", 8'(Req), 8'h1);
    Grant = 4'b0001;
    tick();
    Grant = 4'b0000;
    #1;
    chk("r_done_new", 8'(done), 8'h1);
    chk("r_gerr_new", 8'(grant_err), 8'h0);
    tick();

    // Two grant bits in one cycle: both channels still count
    send(2'd1, 4'd0);
    send(2'd2, 4'd0);
    Grant = 4'b0110;
    tick();
    Grant = 4'b0000;
    #1;
    chk("m_done", 8'(done), 8'h6);
    chk("m_gerr", 8'(grant_err), 8'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
